// File: rtl/uart_sample_receiver_if.sv
// Signal bundle between the PC-side UART line and the sample receiver.
// The master side drives rx and watches the sample/status outputs.
interface uart_sample_receiver_if;
  logic        rx;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        frame_err;
  logic        sync_err;
  logic        busy;

  modport master (
    output rx,
    input  sample_out, sample_valid, frame_err, sync_err, busy
  );

  modport slave (
    input  rx,
    output sample_out, sample_valid, frame_err, sync_err, busy
  );
endinterface

// File: rtl/uart_sample_receiver.sv
// 8N1 UART receiver that pairs bytes (MSB first) into 16-bit samples.
// An inter-byte timeout drops a stranded MSB so pairing resynchronises.
module uart_sample_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PAIR_TIMEOUT = 17360
) (
  input logic                    clk,
  input logic                    rst,
  uart_sample_receiver_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(PAIR_TIMEOUT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(PAIR_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic            rx_meta_r, rx_sync_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic [7:0]      msb_r;
  logic            have_msb_r;
  logic [TW-1:0]   to_cnt_r;
  logic [15:0]     sample_out_r;
  logic            sample_valid_r, frame_err_r, sync_err_r, busy_r;
  logic            byte_done_s, stop_bad_s;

  // Two-flop synchroniser; reset high so reset release never looks like a start bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= bus.rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Bit FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Bit FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!rx_sync_r) state_s = START;
        else            state_s = IDLE;
      end
      START: begin
        if (cnt_r == HALF_LAST) state_s = rx_sync_r ? IDLE : DATA;
        else                    state_s = START;
      end
      DATA: begin
        if (cnt_r == BIT_LAST && bit_idx_r == 3'd7) state_s = STOP;
        else                                        state_s = DATA;
      end
      STOP: begin
        if (cnt_r == BIT_LAST) state_s = rx_sync_r ? IDLE : WAIT_HIGH;
        else                   state_s = STOP;
      end
      WAIT_HIGH: begin
        if (rx_sync_r) state_s = IDLE;
        else           state_s = WAIT_HIGH;
      end
      default: state_s = IDLE;
    endcase
  end

  // Bit FSM outputs: stop-bit verdict in the stop sampling cycle
  always_comb begin
    byte_done_s = 1'b0;
    stop_bad_s  = 1'b0;
    case (state_r)
      STOP: begin
        if (cnt_r == BIT_LAST) begin
          byte_done_s = rx_sync_r;
          stop_bad_s  = !rx_sync_r;
        end else begin
          byte_done_s = 1'b0;
          stop_bad_s  = 1'b0;
        end
      end
      default: begin
        byte_done_s = 1'b0;
        stop_bad_s  = 1'b0;
      end
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      if (state_r == IDLE || state_r == WAIT_HIGH || state_s != state_r) begin
        cnt_r <= '0;
      end else if (state_r == DATA && cnt_r == BIT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      if (state_r == IDLE) begin
        bit_idx_r <= 3'd0;
      end else if (state_r == DATA && cnt_r == BIT_LAST) begin
        bit_idx_r <= bit_idx_r + 3'd1;
        shift_r   <= {rx_sync_r, shift_r[7:1]};
      end
    end
  end

  // Pair assembler and MSB timeout; a completing LSB beats a same-cycle timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msb_r          <= 8'h00;
      have_msb_r     <= 1'b0;
      to_cnt_r       <= '0;
      sample_out_r   <= 16'h0000;
      sample_valid_r <= 1'b0;
      sync_err_r     <= 1'b0;
    end else begin
      sample_valid_r <= 1'b0;
      sync_err_r     <= 1'b0;
      if (byte_done_s) begin
        if (have_msb_r) begin
          sample_out_r   <= {msb_r, shift_r};
          sample_valid_r <= 1'b1;
          have_msb_r     <= 1'b0;
        end else begin
          msb_r      <= shift_r;
          have_msb_r <= 1'b1;
          to_cnt_r   <= '0;
        end
      end else if (stop_bad_s) begin
        have_msb_r <= 1'b0;
      end else if (have_msb_r) begin
        if (to_cnt_r == TO_LAST) begin
          have_msb_r <= 1'b0;
          sync_err_r <= 1'b1;
        end else begin
          to_cnt_r <= to_cnt_r + TW'(1);
        end
      end
    end
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      frame_err_r <= stop_bad_s;
      busy_r      <= (state_s != IDLE);
    end
  end

  assign bus.sample_out   = sample_out_r;
  assign bus.sample_valid = sample_valid_r;
  assign bus.frame_err    = frame_err_r;
  assign bus.sync_err     = sync_err_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_uart_sample_receiver.sv
// Directed bench for uart_sample_receiver with 16 clocks per bit and a 400-cycle pair timeout.
module tb_uart_sample_receiver;
  localparam int NB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_sample_receiver_if bus ();

  uart_sample_receiver #(.CLKS_PER_BIT(NB), .PAIR_TIMEOUT(400)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int valid_cnt = 0, valid_cyc = 0, fe_cnt = 0, se_cnt = 0, se_cyc = 0;
  bit saw_1122 = 1'b0, saw_77 = 1'b0;

  always @(negedge clk) begin
    if (bus.sample_valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      if (bus.sample_out == 16'h1122) saw_1122 = 1'b1;
      if (bus.sample_out[15:8] == 8'h77 || bus.sample_out[7:0] == 8'h77) saw_77 = 1'b1;
    end
    if (bus.frame_err) fe_cnt = fe_cnt + 1;
    if (bus.sync_err) begin
      se_cnt = se_cnt + 1;
      se_cyc = cyc;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the stop bit ends
  task automatic send_byte(input logic [7:0] b, input logic stop, output int k);
    k = cyc;
    bus.rx = 1'b0;
    repeat (NB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      repeat (NB) @(negedge clk);
    end
    bus.rx = stop;
    repeat (NB) @(negedge clk);
  endtask

  initial begin
    int k0, k1, n, vb, fb, sb, sv;
    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sample_out", int'(bus.sample_out), 0);
    check("rst_sample_valid", int'(bus.sample_valid), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    check("rst_sync_err", int'(bus.sync_err), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: back-to-back 0x12, 0x34
    send_byte(8'h12, 1'b1, k0);
    send_byte(8'h34, 1'b1, k1);
    repeat (2) @(negedge clk);
    check("t1_valid_count", valid_cnt, 1);
    check("t1_sample", int'(bus.sample_out), 32'h1234);
    check("t1_latency", valid_cyc, k1 + 155);
    check("t1_no_frame_err", fe_cnt, 0);
    check("t1_no_sync_err", se_cnt, 0);

    // 2: negative sample then small positive
    vb = valid_cnt;
    send_byte(8'hFF, 1'b1, k0);
    send_byte(8'h85, 1'b1, k1);
    repeat (2) @(negedge clk);
    check("t2_sample_ff85", int'(bus.sample_out), 32'hFF85);
    sv = $signed(bus.sample_out);
    check("t2_signed", sv, -123);
    send_byte(8'h00, 1'b1, k0);
    send_byte(8'h01, 1'b1, k1);
    repeat (2) @(negedge clk);
    check("t2_sample_0001", int'(bus.sample_out), 32'h0001);
    check("t2_valid_count", valid_cnt - vb, 2);

    // 3: 5-cycle glitch on rx
    vb = valid_cnt; fb = fe_cnt;
    bus.rx = 1'b0;
    repeat (5) @(negedge clk);
    bus.rx = 1'b1;
    check("t3_busy_seen", int'(bus.busy), 1);
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_busy_drop_in_9", int'(n <= 9), 1);
    check("t3_no_valid", valid_cnt - vb, 0);
    check("t3_no_frame_err", fe_cnt - fb, 0);
    repeat (10) @(negedge clk);
    send_byte(8'hA5, 1'b1, k0);
    send_byte(8'h5A, 1'b1, k1);
    repeat (2) @(negedge clk);
    check("t3_sample", int'(bus.sample_out), 32'hA55A);

    // 4: bad stop bit followed by a held break
    vb = valid_cnt; fb = fe_cnt;
    send_byte(8'h77, 1'b0, k0);
    repeat (100) @(negedge clk);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    check("t4_one_frame_err", fe_cnt - fb, 1);
    send_byte(8'hAB, 1'b1, k0);
    send_byte(8'hCD, 1'b1, k1);
    repeat (2) @(negedge clk);
    check("t4_sample", int'(bus.sample_out), 32'hABCD);
    check("t4_valid_count", valid_cnt - vb, 1);
    check("t4_no_77", int'(saw_77), 0);

    // 5: stranded MSB times out
    vb = valid_cnt; sb = se_cnt;
    send_byte(8'h55, 1'b1, k0);
    repeat (500) @(negedge clk);
    check("t5_one_sync_err", se_cnt - sb, 1);
    check("t5_sync_err_time", se_cyc, k0 + 555);
    check("t5_no_valid", valid_cnt - vb, 0);
    send_byte(8'h01, 1'b1, k0);
    send_byte(8'h02, 1'b1, k1);
    repeat (2) @(negedge clk);
    check("t5_sample", int'(bus.sample_out), 32'h0102);
    check("t5_sync_err_total", se_cnt - sb, 1);

    // 6: reset in the middle of the LSB byte
    vb = valid_cnt;
    send_byte(8'h11, 1'b1, k0);
    bus.rx = 1'b0;
    repeat (NB) @(negedge clk);
    bus.rx = 1'b0;
    repeat (NB) @(negedge clk);
    bus.rx = 1'b1;
    repeat (NB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_sample_out", int'(bus.sample_out), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    send_byte(8'h33, 1'b1, k0);
    send_byte(8'h44, 1'b1, k1);
    repeat (2) @(negedge clk);
    check("t6_sample", int'(bus.sample_out), 32'h3344);
    check("t6_no_1122", int'(saw_1122), 0);
    check("t6_valid_count", valid_cnt - vb, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
